// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry defaults and the register
// address/data types reused by the ALU operand path.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/grf_rdport.sv
// One combinational register-file read port: array select, $0 forced to zero,
// and a write-before-read bypass when GRF_BYPASS_EN is defined.
module grf_rdport
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

`ifdef GRF_BYPASS_EN
  always_comb begin
    rd = regs[ra];
    if (byp_en && (ra == wa)) rd = wd;
    // Zero check last so the bypass can never leak a value onto $0.
    if (ra == ADDR_W'(REG_ZERO)) rd = '0;
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_en, wa, wd};

  always_comb begin
    rd = regs[ra];
    if (ra == ADDR_W'(REG_ZERO)) rd = '0;
  end
`endif

endmodule

// File: rtl/grf.sv
// General register file: one write port, two combinational read ports, $0
// hard-wired to zero. Define GRF_BYPASS_EN for same-cycle write-to-read forwarding.
module grf
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       pc,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_en;
  logic              byp_en;

  assign wr_en  = we && (wa != ADDR_W'(REG_ZERO));
  // Forwarding is suppressed during reset so reads stay zero while rst_n is low.
  assign byp_en = wr_en && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  grf_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .ra     (ra1),
    .regs   (regs),
    .byp_en (byp_en),
    .wa     (wa),
    .wd     (wd),
    .rd     (rd1)
  );

  grf_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .ra     (ra2),
    .regs   (regs),
    .byp_en (byp_en),
    .wa     (wa),
    .wd     (wd),
    .rd     (rd2)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) $display("@%08h: $%0d <= %08h", pc, wa, wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_grf.sv
// Directed self-checking bench for grf (default 32x32 geometry).
module tb_grf;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;

  grf #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .pc    (pc),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; pc = '0; ra1 = 5'd5; ra2 = 5'd31;
    #2;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    tick(); tick();
    #3 rst_n = 1'b1;
    tick();

    // Write to $0 is discarded
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0;
    tick();
    we = 1'b0;
    check("zero_wr_c1", rd1, 32'h0);
    tick();
    check("zero_wr_c2", rd1, 32'h0);

    // Same address on both ports
    wr(5'd8, 32'hDEAD_BEEF);
    ra1 = 5'd8; ra2 = 5'd8;
    #1;
    check("dual_rd1", rd1, 32'hDEAD_BEEF);
    check("dual_rd2", rd2, 32'hDEAD_BEEF);

    // Same-cycle write/read of $9
    wr(5'd9, 32'h0000_0011);
    we = 1'b1; wa = 5'd9; wd = 32'h0000_00AA; ra1 = 5'd9; ra2 = 5'd0;
    #1;
`ifdef GRF_BYPASS_EN
    check("raw_same", rd1, 32'h0000_00AA);
`else
    check("raw_same", rd1, 32'h0000_0011);
`endif
    check("raw_ra0", rd2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("raw_next", rd1, 32'h0000_00AA);

    // we=0 leaves $3 unchanged
    we = 1'b0; wa = 5'd3; wd = 32'h7; ra1 = 5'd3;
    tick();
    check("we0_keep", rd1, 32'h0);

    // Back-to-back writes: last one wins
    wr(5'd10, 32'h1);
    wr(5'd10, 32'h2);
    ra1 = 5'd10;
    #1;
    check("b2b_last", rd1, 32'h2);

    // Sweep all addresses with addr*4
    for (int a = 0; a < 32; a++) wr(5'(a), 32'(a * 4));
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(31 - a);
      #1;
      check($sformatf("sweep_rd1_%0d", a), rd1, (a == 0) ? 32'h0 : 32'(a * 4));
      check($sformatf("sweep_rd2_%0d", 31 - a), rd2, (a == 31) ? 32'h0 : 32'((31 - a) * 4));
    end

    // Traced write of $31
    pc = 32'h0000_3000;
    wr(5'd31, 32'h0000_3004);
    ra1 = 5'd31;
    #1;
    check("trace_wr31", rd1, 32'h0000_3004);

    // Asynchronous reset mid-run
    wr(5'd5, 32'h1234_5678);
    ra1 = 5'd5; ra2 = 5'd8;
    #1;
    check("pre_rst_5", rd1, 32'h1234_5678);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_rd2", rd2, 32'h0);

    // Write during reset is lost; first write after release is honoured
    we = 1'b1; wa = 5'd6; wd = 32'h55; ra1 = 5'd6;
    #1;
    check("rst_byp_rd1", rd1, 32'h0);
    tick();
    check("rst_wr_lost", rd1, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    we = 1'b0;
    #1;
    check("post_rst_wr", rd1, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
